result_uart_tx: RTL and testbench

//  Consumer end of the solver result interface (total_count/done). On the

---
 rtl/result_uart_tx_pkg.sv | 30 +++
 rtl/uart_tx_byte.sv | 75 +++++++
 rtl/result_uart_tx.sv | 161 ++++++++++++++++
 tb/tb_result_uart_tx.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/result_uart_tx_pkg.sv
// Shared definitions for the result UART: ASCII codes, FSM states, digit count, frame size.
// RESULT_TX_PARITY_EN adds an even-parity bit to every frame.
package result_uart_tx_pkg;

   localparam logic [7:0] CHAR_0  = 8'h30;
   localparam logic [7:0] CHAR_CR = 8'h0D;
   localparam logic [7:0] CHAR_LF = 8'h0A;

`ifdef RESULT_TX_PARITY_EN
   localparam int unsigned FRAME_BITS = 11;
`else
   localparam int unsigned FRAME_BITS = 10;
`endif

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CONVERT,
      ST_SKIP,
      ST_DIGITS,
      ST_CR,
      ST_LF,
      ST_FIN
   } state_t;

   // ceil(w * log10(2)) in fixed point; w*log10(2) is never an exact integer for w > 0
   function automatic int unsigned ndig(input int unsigned w);
      return (w * 30103 + 99999) / 100000;
   endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// Byte serializer: start, 8 data bits LSB first, optional even parity, stop.
// RESULT_TX_PARITY_EN inserts the parity bit after data bit 7.
module uart_tx_byte
   import result_uart_tx_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 868
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_valid,
   input  logic [7:0] i_data,
   output logic       o_ready_c,
   output logic       o_tx
);

   localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int unsigned BIT_W  = 4;
   localparam int unsigned SH_W   = FRAME_BITS - 1;

   logic              r_active;
   logic [BAUD_W-1:0] r_baud;
   logic [BIT_W-1:0]  r_bit;
   logic [SH_W-1:0]   r_shift;
   logic              r_tx;

   logic              w_bit_end;
   logic              w_last_bit;
   logic              w_take;
   logic [SH_W-1:0]   w_load;

   assign w_bit_end  = (r_baud == BAUD_W'(CLKS_PER_BIT - 1));
   assign w_last_bit = (r_bit == BIT_W'(FRAME_BITS - 1));
   // Accept a new byte while idle or in the final cycle of a stop bit (gapless frames)
   assign o_ready_c  = ~r_active | (w_bit_end & w_last_bit);
   assign w_take     = i_valid & o_ready_c;

`ifdef RESULT_TX_PARITY_EN
   assign w_load = {1'b1, ^i_data, i_data};
`else
   assign w_load = {1'b1, i_data};
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_active <= 1'b0;
         r_baud   <= '0;
         r_bit    <= '0;
         r_shift  <= '0;
         r_tx     <= 1'b1;
      end else if (w_take) begin
         r_active <= 1'b1;
         r_baud   <= '0;
         r_bit    <= '0;
         r_shift  <= w_load;
         r_tx     <= 1'b0;
      end else if (r_active) begin
         if (w_bit_end) begin
            r_baud <= '0;
            if (w_last_bit) begin
               r_active <= 1'b0;
               r_tx     <= 1'b1;
            end else begin
               r_bit   <= r_bit + BIT_W'(1);
               r_tx    <= r_shift[0];
               r_shift <= r_shift >> 1;
            end
         end else begin
            r_baud <= r_baud + BAUD_W'(1);
         end
      end
   end

   assign o_tx = r_tx;

endmodule

// File: rtl/result_uart_tx.sv
// Captures the solver count on a done edge, converts it to decimal and sends it as ASCII + CR LF.
// RESULT_TX_PARITY_EN (see uart_tx_byte) selects 8E1 framing instead of 8N1.
module result_uart_tx
   import result_uart_tx_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 868,
   parameter int unsigned COUNT_W      = 64
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [COUNT_W-1:0] total_count,
   input  logic               done,
   output logic               tx,
   output logic               busy,
   output logic               sent
);

   localparam int unsigned NDIG  = ndig(COUNT_W);
   localparam int unsigned BCD_W = NDIG * 4;
   localparam int unsigned IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam int unsigned CNT_W = $clog2(COUNT_W + 1);

   state_t             r_state;
   logic               r_done_q;
   logic               r_busy;
   logic               r_sent;
   logic [COUNT_W-1:0] r_bin;
   logic [BCD_W-1:0]   r_bcd;
   logic [CNT_W-1:0]   r_cnt;
   logic [IDX_W-1:0]   r_idx;

   logic [BCD_W-1:0]   w_bcd_adj;
   logic [3:0]         w_digit;
   logic               w_valid;
   logic               w_ready;
   logic [7:0]         w_byte;
   logic               w_tx;

   // Double-dabble correction: add 3 to every digit >= 5 before the shift
   always_comb begin
      w_bcd_adj = r_bcd;
      for (int i = 0; i < int'(NDIG); i++) begin
         if (r_bcd[i*4 +: 4] >= 4'd5) begin
            w_bcd_adj[i*4 +: 4] = r_bcd[i*4 +: 4] + 4'd3;
         end
      end
   end

   always_comb begin
      w_digit = '0;
      for (int i = 0; i < int'(NDIG); i++) begin
         if (r_idx == IDX_W'(i)) begin
            w_digit = r_bcd[i*4 +: 4];
         end
      end
   end

   always_comb begin
      w_valid = 1'b0;
      w_byte  = CHAR_0;
      case (r_state)
         ST_DIGITS: begin
            w_valid = 1'b1;
            w_byte  = CHAR_0 | {4'h0, w_digit};
         end
         ST_CR: begin
            w_valid = 1'b1;
            w_byte  = CHAR_CR;
         end
         ST_LF: begin
            w_valid = 1'b1;
            w_byte  = CHAR_LF;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state  <= ST_IDLE;
         r_done_q <= 1'b0;
         r_busy   <= 1'b0;
         r_sent   <= 1'b0;
         r_bin    <= '0;
         r_bcd    <= '0;
         r_cnt    <= '0;
         r_idx    <= '0;
      end else begin
         r_done_q <= done;
         r_sent   <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (done && !r_done_q) begin
                  r_bin   <= total_count;
                  r_bcd   <= '0;
                  r_cnt   <= CNT_W'(COUNT_W);
                  r_busy  <= 1'b1;
                  r_state <= ST_CONVERT;
               end
            end
            ST_CONVERT: begin
               r_bcd <= (w_bcd_adj << 1) | BCD_W'(r_bin[COUNT_W-1]);
               r_bin <= r_bin << 1;
               r_cnt <= r_cnt - CNT_W'(1);
               if (r_cnt == CNT_W'(1)) begin
                  r_idx   <= IDX_W'(NDIG - 1);
                  r_state <= ST_SKIP;
               end
            end
            // Drop leading zeros, but digit 0 is always sent
            ST_SKIP: begin
               if (r_idx != '0 && w_digit == 4'd0) begin
                  r_idx <= r_idx - IDX_W'(1);
               end else begin
                  r_state <= ST_DIGITS;
               end
            end
            ST_DIGITS: begin
               if (w_ready) begin
                  if (r_idx == '0) begin
                     r_state <= ST_CR;
                  end else begin
                     r_idx <= r_idx - IDX_W'(1);
                  end
               end
            end
            ST_CR: begin
               if (w_ready) r_state <= ST_LF;
            end
            ST_LF: begin
               if (w_ready) r_state <= ST_FIN;
            end
            // Serializer is busy with LF; its ready marks the last stop-bit cycle
            ST_FIN: begin
               if (w_ready) begin
                  r_sent  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   uart_tx_byte #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_tx (
      .clk      (clk),
      .rst      (rst),
      .i_valid  (w_valid),
      .i_data   (w_byte),
      .o_ready_c(w_ready),
      .o_tx     (w_tx)
   );

   assign tx   = w_tx;
   assign busy = r_busy;
   assign sent = r_sent;

endmodule

// File: tb/tb_result_uart_tx.sv
// Bench for result_uart_tx: UART line decoder plus a divide-by-ten reference of the ASCII message.
module tb_result_uart_tx;

   localparam int unsigned CPB  = 4;
   localparam int unsigned CW   = 64;
   localparam int unsigned NDIG = 20;
`ifdef RESULT_TX_PARITY_EN
   localparam int unsigned FRM = 11;
`else
   localparam int unsigned FRM = 10;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [63:0] total_count = '0;
   logic        done = 1'b0;
   logic        tx;
   logic        busy;
   logic        sent;

   always #5 clk = ~clk;

   result_uart_tx #(
      .CLKS_PER_BIT(CPB),
      .COUNT_W     (CW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .total_count(total_count),
      .done       (done),
      .tx         (tx),
      .busy       (busy),
      .sent       (sent)
   );

   typedef struct {
      logic [7:0] d;
      logic       par;
      logic       stop;
   } frame_t;

   int          checks   = 0;
   int          failures = 0;
   int          cyc      = 0;
   int          sent_cnt = 0;
   int          glitches = 0;
   frame_t      frames[$];
   int          starts[$];
   logic [7:0]  exp_q[$];

   logic        m_active = 1'b0;
   int          m_bit    = 0;
   int          m_cnt    = 0;
   logic [10:0] m_bits   = '1;
   frame_t      m_f;

   // Line decoder: one sample per cycle at the falling edge
   always @(negedge clk) begin
      cyc = cyc + 1;
      if (sent === 1'b1) sent_cnt = sent_cnt + 1;
      if (rst !== 1'b1) begin
         m_active = 1'b0;
      end else if (!m_active) begin
         if (tx === 1'b0) begin
            m_active  = 1'b1;
            m_bit     = 0;
            m_cnt     = 1;
            m_bits    = '1;
            m_bits[0] = 1'b0;
            starts.push_back(cyc);
         end
      end else begin
         if (m_cnt == int'(CPB)) begin
            m_bit         = m_bit + 1;
            m_cnt         = 1;
            m_bits[m_bit] = tx;
         end else begin
            if (tx !== m_bits[m_bit]) glitches = glitches + 1;
            m_cnt = m_cnt + 1;
         end
         if (m_bit == int'(FRM) - 1 && m_cnt == int'(CPB)) begin
            m_f.d    = m_bits[8:1];
            m_f.par  = m_bits[9];
            m_f.stop = m_bits[FRM-1];
            frames.push_back(m_f);
            m_active = 1'b0;
         end
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks = checks + 1;
      assert (obs === exp) else begin
         failures = failures + 1;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: decimal digits by repeated division, then CR LF
   task automatic build_exp(input logic [63:0] v);
      logic [63:0] t;
      exp_q.delete();
      t = v;
      if (t == 64'd0) exp_q.push_back(8'h30);
      while (t != 64'd0) begin
         exp_q.push_front(8'h30 + 8'(t % 64'd10));
         t = t / 64'd10;
      end
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
   endtask

   task automatic clear_mon();
      frames.delete();
      starts.delete();
      glitches = 0;
   endtask

   task automatic wait_sent(input int base, input int budget, output bit ok);
      int n;
      n = 0;
      while (sent_cnt == base && n < budget) begin
         @(negedge clk);
         n = n + 1;
      end
      ok = (sent_cnt != base);
   endtask

   task automatic check_msg(input string tag, input int t0);
      int n;
      int gaps;
      chk({tag, " nbytes"}, 64'(frames.size()), 64'(exp_q.size()));
      n = (frames.size() < exp_q.size()) ? frames.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         chk($sformatf("%s byte%0d", tag, i), 64'(frames[i].d), 64'(exp_q[i]));
         chk($sformatf("%s stop%0d", tag, i), 64'(frames[i].stop), 64'd1);
`ifdef RESULT_TX_PARITY_EN
         chk($sformatf("%s par%0d", tag, i), 64'(frames[i].par), 64'(^exp_q[i]));
`endif
      end
      chk({tag, " bit_hold"}, 64'(glitches), 64'd0);
      gaps = 0;
      for (int i = 1; i < starts.size(); i++) begin
         if (starts[i] - starts[i-1] != int'(FRM * CPB)) gaps = gaps + 1;
      end
      chk({tag, " gapless"}, 64'(gaps), 64'd0);
      if (starts.size() > 0) begin
         chk({tag, " latency"}, 64'(starts[0] - t0 <= int'(CW + NDIG + 4)), 64'd1);
      end
   endtask

   task automatic run_value(input string tag, input logic [63:0] v);
      int base;
      int t0;
      bit ok;
      build_exp(v);
      clear_mon();
      base = sent_cnt;
      @(posedge clk);
      #1;
      total_count = v;
      done        = 1'b1;
      t0          = cyc + 1;
      @(posedge clk);
      #1;
      done        = 1'b0;
      total_count = {$urandom, $urandom};
      wait_sent(base, 3000, ok);
      chk({tag, " sent_seen"}, 64'(ok), 64'd1);
      @(negedge clk);
      @(negedge clk);
      chk({tag, " sent_once"}, 64'(sent_cnt - base), 64'd1);
      chk({tag, " busy_after"}, 64'(busy), 64'd0);
      chk({tag, " tx_idle"}, 64'(tx), 64'd1);
      check_msg(tag, t0);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] v;
      int          base;
      int          t0;
      int          n;
      bit          ok;

      rst = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset tx", 64'(tx), 64'd1);
      chk("reset busy", 64'(busy), 64'd0);
      chk("reset sent", 64'(sent), 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (3) @(posedge clk);

      run_value("zero", 64'd0);
      run_value("v1234", 64'd1234);
      run_value("max", 64'hFFFF_FFFF_FFFF_FFFF);
      run_value("v10", 64'd10);
      for (int k = 0; k < 8; k++) begin
         v = {$urandom, $urandom} >> $urandom_range(0, 63);
         run_value($sformatf("rand%0d", k), v);
      end

      // done held high, with an extra rising edge while busy
      v = {$urandom, $urandom} >> $urandom_range(0, 63);
      build_exp(v);
      clear_mon();
      base = sent_cnt;
      @(posedge clk);
      #1;
      total_count = v;
      done        = 1'b1;
      t0          = cyc + 1;
      repeat (60) @(posedge clk);
      @(negedge clk);
      chk("hold busy_mid", 64'(busy), 64'd1);
      @(posedge clk);
      #1;
      done = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      done = 1'b1;
      repeat (10000) @(posedge clk);
      #1;
      done = 1'b0;
      repeat (200) @(posedge clk);
      @(negedge clk);
      chk("hold sent_once", 64'(sent_cnt - base), 64'd1);
      chk("hold busy_after", 64'(busy), 64'd0);
      check_msg("hold", t0);

      // Reset during the data bits of the second byte
      v = 64'(1000 + $urandom_range(0, 8999));
      build_exp(v);
      clear_mon();
      base = sent_cnt;
      @(posedge clk);
      #1;
      total_count = v;
      done        = 1'b1;
      @(posedge clk);
      #1;
      done = 1'b0;
      n = 0;
      while (!(frames.size() == 1 && m_active && m_bit >= 2 && m_bit <= 8) && n < 3000) begin
         @(negedge clk);
         n = n + 1;
      end
      chk("abort reached_byte2", 64'(n < 3000), 64'd1);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      chk("abort tx", 64'(tx), 64'd1);
      chk("abort busy", 64'(busy), 64'd0);
      repeat (400) @(negedge clk);
      chk("abort no_sent", 64'(sent_cnt - base), 64'd0);
      chk("abort tx_quiet", 64'(tx), 64'd1);
      wait_sent(base, 1, ok);
      run_value("after_abort", {$urandom, $urandom} >> $urandom_range(0, 63));

`ifdef RESULT_TX_PARITY_EN
      run_value("parity_one", 64'd1);
      if (frames.size() > 0) begin
         chk("parity 0x31 bit", 64'(frames[0].par), 64'd1);
      end
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
